// File: rtl/reg_group_bank.sv
// reg_group_bank: register file with PC, interrupt shadow bank, system register and sideband delay line
module reg_group_bank #(
  parameter int WIDTH = 32,
  parameter int NREG = 16,
  parameter logic [31:0] RESET_PC = 32'h00010000,
  parameter logic [NREG-1:0] SAVE_MASK = '1,
  parameter int PIPE_STAGES = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  all_rst,
  input  logic                  wb0_en,
  input  logic [AW-1:0]         wb0_addr,
  input  logic [WIDTH-1:0]      wb0_data,
  input  logic                  wb1_en,
  input  logic [AW-1:0]         wb1_addr,
  input  logic [WIDTH-1:0]      wb1_data,
  input  logic [AW-1:0]         rd0_addr,
  output logic [WIDTH-1:0]      rd0_data,
  input  logic [AW-1:0]         rd1_addr,
  output logic [WIDTH-1:0]      rd1_data,
  output logic [NREG*WIDTH-1:0] regs_flat,
  input  logic [WIDTH-1:0]      next_pc,
  input  logic                  pc_stop,
  output logic [WIDTH-1:0]      pc,
  input  logic                  irq_ask,
  input  logic [WIDTH-1:0]      irq_pc,
  input  logic                  irq_ret,
  output logic [WIDTH-1:0]      ipc,
  output logic [WIDTH-1:0]      sys,
  input  logic                  sys_wr,
  input  logic [WIDTH-1:0]      sys_data,
  output logic                  shadow_valid,
  output logic                  irq_err,
  input  logic [WIDTH-1:0]      this_addr,
  input  logic                  this_running,
  input  logic                  this_irq,
  input  logic [7:0]            this_irq_num,
  output logic [WIDTH-1:0]      next_addr,
  output logic                  next_running,
  output logic                  next_irq,
  output logic [7:0]            next_irq_num
);
  localparam logic [WIDTH-1:0] PC0 = WIDTH'(RESET_PC);
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] shadow [NREG];
  logic [WIDTH+9:0] sb [PIPE_STAGES];
  logic ret_ok, ask_ok;
  assign ret_ok = irq_ret && shadow_valid;
  assign ask_ok = irq_ask && !shadow_valid && !irq_ret;
  assign rd0_data = regs[rd0_addr];
  assign rd1_data = regs[rd1_addr];
  assign {next_addr, next_running, next_irq, next_irq_num} = sb[PIPE_STAGES-1];
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign regs_flat[i*WIDTH +: WIDTH] = regs[i];
    // register i: restore on return, otherwise write-back (wb0 first); register 0 is never written
    always_ff @(posedge clk or negedge all_rst) begin
      if (!all_rst) begin
        regs[i] <= '0;
        shadow[i] <= '0;
      end else begin
        regs[i] <= ret_ok && SAVE_MASK[i] ? shadow[i] :
                   ask_ok || i == 0 ? regs[i] :
                   wb0_en && wb0_addr == AW'(i) ? wb0_data :
                   wb1_en && wb1_addr == AW'(i) ? wb1_data : regs[i];
        shadow[i] <= ask_ok && SAVE_MASK[i] ? regs[i] : shadow[i];
      end
    end
  end
  // pc, saved pc, system register, shadow occupancy and the registered error pulse
  always_ff @(posedge clk or negedge all_rst) begin
    if (!all_rst) begin
      pc <= PC0;
      ipc <= '0;
      sys <= '0;
      shadow_valid <= 1'b0;
      irq_err <= 1'b0;
    end else begin
      pc <= ret_ok ? ipc : ask_ok ? irq_pc : pc_stop ? pc : next_pc;
      ipc <= ask_ok ? pc : ipc;
      sys <= ask_ok ? '0 : sys_wr ? sys_data : sys;
      shadow_valid <= ret_ok ? 1'b0 : ask_ok ? 1'b1 : shadow_valid;
      irq_err <= (irq_ret && !shadow_valid) || (irq_ask && shadow_valid && !irq_ret);
    end
  end
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_sb
    if (s == 0) begin : g_head
      // first sideband stage samples the inputs every cycle
      always_ff @(posedge clk or negedge all_rst) begin
        if (!all_rst) sb[s] <= '0;
        else sb[s] <= {this_addr, this_running, this_irq, this_irq_num};
      end
    end else begin : g_tail
      // later stages shift unconditionally
      always_ff @(posedge clk or negedge all_rst) begin
        if (!all_rst) sb[s] <= '0;
        else sb[s] <= sb[s-1];
      end
    end
  end
endmodule

// File: tb/tb_reg_group_bank.sv
// tb_reg_group_bank: directed checks of register bank, pc/interrupt flow and a sideband scoreboard
module tb_reg_group_bank;
  localparam int W = 32;
  logic clk = 1'b0, all_rst = 1'b0;
  logic wb0_en = 0, wb1_en = 0;
  logic [3:0] wb0_addr = 0, wb1_addr = 0, rd0_addr = 0, rd1_addr = 0;
  logic [W-1:0] wb0_data = 0, wb1_data = 0, rd0_data, rd1_data;
  logic [16*W-1:0] regs_flat;
  logic [W-1:0] next_pc = 0, pc, irq_pc = 0, ipc, sys, sys_data = 0;
  logic pc_stop = 1, irq_ask = 0, irq_ret = 0, sys_wr = 0, shadow_valid, irq_err;
  logic [W-1:0] this_addr = 0, next_addr;
  logic this_running = 0, this_irq = 0, next_running, next_irq;
  logic [7:0] this_irq_num = 0, next_irq_num;
  int n_tests = 0, n_fail = 0;
  logic [W+9:0] sbq [$];
  bit first = 1;
  always #5 clk = ~clk;
  reg_group_bank #(.PIPE_STAGES(3)) dut (
    .clk(clk), .all_rst(all_rst),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .regs_flat(regs_flat), .next_pc(next_pc), .pc_stop(pc_stop), .pc(pc),
    .irq_ask(irq_ask), .irq_pc(irq_pc), .irq_ret(irq_ret), .ipc(ipc), .sys(sys),
    .sys_wr(sys_wr), .sys_data(sys_data), .shadow_valid(shadow_valid), .irq_err(irq_err),
    .this_addr(this_addr), .this_running(this_running), .this_irq(this_irq), .this_irq_num(this_irq_num),
    .next_addr(next_addr), .next_running(next_running), .next_irq(next_irq), .next_irq_num(next_irq_num)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    this_addr = first ? 32'h40 : $urandom;
    first = 0;
    this_running = 1'($urandom_range(0, 1));
    this_irq = 1'($urandom_range(0, 1));
    this_irq_num = 8'($urandom_range(0, 255));
    sbq.push_back({this_addr, this_running, this_irq, this_irq_num});
    @(posedge clk);
    #1;
    if (sbq.size() == 3) chk("sideband", {next_addr, next_running, next_irq, next_irq_num}, sbq.pop_front());
  endtask
  initial begin
    #12;
    chk("rst_pc", pc, 32'h00010000);
    chk("rst_regs", 64'(regs_flat != '0), 0);
    chk("rst_sv", shadow_valid, 0);
    chk("rst_ipc", ipc, 0);
    chk("rst_sys", sys, 0);
    chk("rst_err", irq_err, 0);
    chk("rst_sb", next_addr, 0);
    @(negedge clk) all_rst = 1;
    step();
    chk("pc_hold_after_rst", pc, 32'h00010000);
    wb0_en = 1; wb0_addr = 3; wb0_data = 32'hAAAA0000;
    wb1_en = 1; wb1_addr = 3; wb1_data = 32'h5555;
    step();
    rd0_addr = 3; #1;
    chk("collide_r3", rd0_data, 32'hAAAA0000);
    wb0_addr = 2; wb0_data = 32'h22; wb1_addr = 0; wb1_data = 32'hFFFF; rd1_addr = 2; #1;
    chk("no_bypass", rd1_data, 0);
    step();
    rd0_addr = 0; #1;
    chk("r0_read", rd0_data, 0);
    chk("r2_read", rd1_data, 32'h22);
    chk("flat_r0", regs_flat[31:0], 0);
    chk("flat_r3", regs_flat[3*W +: W], 32'hAAAA0000);
    wb0_en = 0; wb1_addr = 4; wb1_data = 32'h44;
    step();
    rd0_addr = 4; #1;
    chk("wb1_r4", rd0_data, 32'h44);
    wb1_en = 0; wb0_en = 1; wb0_addr = 5; wb0_data = 32'h12;
    sys_wr = 1; sys_data = 32'h77; pc_stop = 0; next_pc = 32'h100;
    step();
    chk("pc_load", pc, 32'h100);
    chk("sys_load", sys, 32'h77);
    wb0_en = 0; sys_wr = 0; pc_stop = 1; next_pc = 32'h200;
    step();
    chk("stall1", pc, 32'h100);
    step();
    chk("stall2", pc, 32'h100);
    irq_ask = 1; irq_pc = 32'h8000; wb0_en = 1; wb0_addr = 6; wb0_data = 32'h66; sys_wr = 1; sys_data = 32'h55;
    step();
    irq_ask = 0; sys_wr = 0;
    chk("irq_pc", pc, 32'h8000);
    chk("irq_ipc", ipc, 32'h100);
    chk("irq_sys", sys, 0);
    chk("irq_sv", shadow_valid, 1);
    chk("irq_err0", irq_err, 0);
    rd1_addr = 6; #1;
    chk("irq_wb_drop", rd1_data, 0);
    wb0_addr = 5; wb0_data = 32'h99;
    step();
    rd0_addr = 5; #1;
    chk("isr_r5", rd0_data, 32'h99);
    wb0_en = 0; irq_ask = 1; irq_pc = 32'h9000;
    step();
    chk("nest_err", irq_err, 1);
    chk("nest_pc", pc, 32'h8000);
    chk("nest_ipc", ipc, 32'h100);
    irq_ask = 0;
    step();
    chk("nest_err_pulse", irq_err, 0);
    irq_ask = 1; irq_ret = 1; wb0_en = 1; wb0_addr = 5; wb0_data = 32'h33;
    step();
    irq_ask = 0; wb0_en = 0;
    chk("ret_pc", pc, 32'h100);
    chk("ret_r5", rd0_data, 32'h12);
    chk("ret_sv", shadow_valid, 0);
    chk("ret_err", irq_err, 0);
    step();
    chk("bad_ret_err", irq_err, 1);
    chk("bad_ret_pc", pc, 32'h100);
    irq_ret = 0;
    step();
    chk("bad_ret_pulse", irq_err, 0);
    irq_ask = 1; irq_pc = 32'hA000;
    step();
    irq_ask = 0;
    chk("pre_rst_sv", shadow_valid, 1);
    @(posedge clk);
    #3 all_rst = 0;
    #1;
    chk("arst_pc", pc, 32'h00010000);
    chk("arst_regs", 64'(regs_flat != '0), 0);
    chk("arst_sv", shadow_valid, 0);
    chk("arst_ipc", ipc, 0);
    chk("arst_sb", next_addr, 0);
    sbq.delete();
    @(negedge clk) all_rst = 1;
    pc_stop = 0; next_pc = 32'h300;
    step();
    chk("post_rst_pc", pc, 32'h300);
    chk("post_rst_sv", shadow_valid, 0);
    pc_stop = 1; irq_ret = 1;
    step();
    chk("post_rst_ret_err", irq_err, 1);
    irq_ret = 0;
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_group_bank.md
REG_GROUP_BANK -- requirements
Module: reg_group_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width of every register.
REQ-002 SHALL provide parameter NREG, default 16, general-register count (power of two, 4..64); AW = log2(NREG).
REQ-003 SHALL provide parameter RESET_PC, default 32'h00010000 (zero-extended/truncated to WIDTH), PC value after reset.
REQ-004 SHALL provide parameter SAVE_MASK, default all ones (NREG bits); bit i set = register i shadowed on interrupt entry.
REQ-005 SHALL provide parameter PIPE_STAGES, default 1, range 1..4, sideband delay depth.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 all_rst  in  1  reset, asynchronous, active-low.
REQ-008 wb0_en, wb1_en  in  1 each  write-back port enables.
REQ-009 wb0_addr, wb1_addr  in  AW each  write-back target index.
REQ-010 wb0_data, wb1_data  in  WIDTH each  write-back data.
REQ-011 rd0_addr, rd1_addr  in  AW each; rd0_data, rd1_data  out  WIDTH each  combinational read ports.
REQ-012 regs_flat  out  NREG*WIDTH  all registers, register i at bits [i*WIDTH +: WIDTH].
REQ-013 next_pc  in  WIDTH; pc_stop  in  1; pc  out  WIDTH  program counter.
REQ-014 irq_ask  in  1; irq_pc  in  WIDTH  interrupt entry request and handler address.
REQ-015 irq_ret  in  1  interrupt return request.
REQ-016 ipc  out  WIDTH; sys  out  WIDTH; sys_wr  in  1; sys_data  in  WIDTH  saved PC and system register.
REQ-017 shadow_valid  out  1; irq_err  out  1  shadow occupancy and one-cycle error pulse.
REQ-018 this_addr in WIDTH, this_running in 1, this_irq in 1, this_irq_num in 8; next_addr, next_running, next_irq, next_irq_num out, same widths.

Function
REQ-019 Register 0 SHALL read as zero on every output; writes to index 0 ignored.
REQ-020 Write ports SHALL update at the rising edge when enabled; wb0 wins when both target the same index.
REQ-021 Read ports SHALL return current register contents (no write-through bypass).
REQ-022 pc SHALL take next_pc each cycle unless pc_stop=1 (hold).
REQ-023 Priority per cycle: irq_ret (when accepted) > irq_ask (when accepted) > write-backs/pc_stop/sys_wr.
REQ-024 Accepted irq_ask (shadow_valid=0, irq_ret=0): pc<=irq_pc, ipc<=pc, sys<=0, shadow[i]<=reg[i] for SAVE_MASK bits, shadow_valid<=1, all write-backs and sys_wr that cycle dropped.
REQ-025 irq_ask with shadow_valid=1 SHALL be ignored and irq_err SHALL pulse high one cycle; no state changes from it; write-backs proceed.
REQ-026 Accepted irq_ret (shadow_valid=1): pc<=ipc, reg[i]<=shadow[i] for SAVE_MASK bits, unmasked registers take write-backs normally, shadow_valid<=0; irq_ask same cycle ignored without irq_err.
REQ-027 irq_ret with shadow_valid=0 SHALL be ignored and irq_err SHALL pulse.
REQ-028 sys SHALL load sys_data when sys_wr=1 and no accepted irq_ask.
REQ-029 Sideband outputs SHALL equal inputs delayed exactly PIPE_STAGES cycles; shift unconditional (no stall).

Reset
REQ-030 Asserting all_rst low SHALL immediately clear registers, shadow bank, ipc, sys, shadow_valid, irq_err and all sideband stages to 0, set pc to RESET_PC.
REQ-031 Reset mid-interrupt SHALL discard shadow contents; first rising edge after release performs normal operation.

Verification
REQ-032 Reset: drive all_rst low asynchronously mid-cycle -> pc=32'h00010000, regs_flat=0, shadow_valid=0 before next edge.
REQ-033 Write collision: wb0 (addr 3, 0xAAAA0000) and wb1 (addr 3, 0x5555) same cycle -> reg3=0xAAAA0000; wb1 to 0 -> rd0_data(0)=0.
REQ-034 Interrupt round trip: reg5=0x12, pc=0x100, irq_ask, irq_pc=0x8000 -> pc=0x8000, ipc=0x100, sys=0; write reg5=0x99; irq_ret -> reg5=0x12, pc=0x100, shadow_valid=0.
REQ-035 Nesting: second irq_ask while shadow_valid=1 -> irq_err one cycle, pc unchanged; irq_ret at shadow_valid=0 -> irq_err.
REQ-036 Simultaneous irq_ask+irq_ret with shadow_valid=1 -> return performed, shadow_valid=0, no irq_err.
REQ-037 Sideband with PIPE_STAGES=3: this_addr=0x40 at cycle n -> next_addr=0x40 at cycle n+3; pc_stop=1 holds pc for each stalled cycle.
